// File: rtl/cpu_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Optional feature macro: LOADER_CHECKSUM_EN adds the CHECK state (checksum byte).
package cpu_loader_pkg;

    // Loader FSM states; CHECK exists only when the trailing checksum is enabled
    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DAT_HI,
        DAT_LO,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERR
    } state_t;

    // Frame start marker, only recognised outside a frame
    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    // One program memory instruction word
    typedef logic [11:0] instr_word_t;

    // True while a frame is being received (CPU held, inter-byte timer armed)
    function automatic logic is_loading(input state_t s);
        return !((s == IDLE) || (s == DONE) || (s == ERR));
    endfunction

endpackage

// File: rtl/cpu_loader_timeout.sv
// Inter-byte watchdog: counts consecutive idle cycles while enabled and
// flags expiry on the CYCLES-th idle cycle. restart or !enable clear it.
module cpu_loader_timeout #(
    parameter int unsigned CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next idle count and expiry flag; cnt_q idle cycles have already elapsed
    always_comb begin
        expired = enable && !restart && (cnt_q == CW'(CYCLES - 1));
        cnt_d   = cnt_q;
        if (!enable || restart) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Idle counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_program_loader.sv
// Serial program loader: parses A5 / count / 12-bit words from a byte stream,
// writes program memory and holds the CPU in reset while a load is running.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing mod-256 checksum byte).
module cpu_program_loader
    import cpu_loader_pkg::*;
#(
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [ADDR_W-1:0] mem_address,
    output logic [11:0]       mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // Largest legal word count: the whole address space
    localparam logic [31:0] MAX_COUNT = 32'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [3:0]        hi_nib_q, hi_nib_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    instr_word_t       mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic              tmr_enable;
    logic              tmr_expired;
    logic              go_err;
    logic              go_done;
    logic [15:0]       new_count;
    logic [15:0]       next_idx;

    // Inter-byte watchdog: armed during a frame, reloaded by every byte
    assign tmr_enable = is_loading(state_q);

    cpu_loader_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .restart (rx_valid),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // Frame parser: next state, memory write and status flags
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        word_idx_d    = word_idx_q;
        hi_nib_d      = hi_nib_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;
        cpu_hold_d    = cpu_hold_q;
        done_d        = done_q;
        error_d       = error_q;
        go_err        = 1'b0;
        go_done       = 1'b0;
        new_count     = {count_q[15:8], rx_byte};
        next_idx      = 16'(word_idx_q) + 16'd1;
`ifdef LOADER_CHECKSUM_EN
        sum_d         = sum_q;
`endif

        case (state_q)
            CNT_HI: begin
                if (rx_valid) begin
                    count_d[15:8] = rx_byte;
                    state_d       = CNT_LO;
                end
            end
            CNT_LO: begin
                if (rx_valid) begin
                    count_d = new_count;
                    if ((new_count == 16'd0) || (32'(new_count) > MAX_COUNT)) begin
                        go_err = 1'b1;
                    end else begin
                        state_d = DAT_HI;
                    end
                end
            end
            DAT_HI: begin
                if (rx_valid) begin
                    if (rx_byte[7:4] != 4'd0) begin
                        go_err = 1'b1;
                    end else begin
                        hi_nib_d = rx_byte[3:0];
                        state_d  = DAT_LO;
                    end
                end
            end
            DAT_LO: begin
                if (rx_valid) begin
                    mem_data_d    = {hi_nib_q, rx_byte};
                    mem_address_d = word_idx_q;
                    mem_wren_d    = 1'b1;
                    if (next_idx == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        go_done = 1'b1;
`endif
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = DAT_HI;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (rx_valid) begin
                    if (rx_byte == sum_q) begin
                        go_done = 1'b1;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end
`endif
            default: begin
                // IDLE, DONE, ERR: only the header starts a new frame
                if (rx_valid && (rx_byte == HEADER_BYTE)) begin
                    state_d    = CNT_HI;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cpu_hold_d = 1'b1;
                    word_idx_d = '0;
                end
            end
        endcase

`ifdef LOADER_CHECKSUM_EN
        // Running sum over count and data bytes; restarted outside a frame
        if (!is_loading(state_q)) begin
            sum_d = 8'd0;
        end else if (rx_valid && (state_q != CHECK)) begin
            sum_d = sum_q + rx_byte;
        end
`endif

        // Timer expiry only fires on a cycle without rx_valid
        if (tmr_expired) begin
            go_err = 1'b1;
        end

        if (go_err) begin
            state_d    = ERR;
            error_d    = 1'b1;
            cpu_hold_d = 1'b0;
        end else if (go_done) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
        end
    end

    // FSM and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            word_idx_q    <= '0;
            hi_nib_q      <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            cpu_hold_q    <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            word_idx_q    <= word_idx_d;
            hi_nib_q      <= hi_nib_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            cpu_hold_q    <= cpu_hold_d;
            done_q        <= done_d;
            error_q       <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q         <= sum_d;
`endif
        end
    end

    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;
    assign cpu_hold    = cpu_hold_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule
